echo_ctrl: RTL
==============

Name: echo_ctrl

Overview:
- Sample-rate sequencer for the single-port circular delay buffer in the echo/delay pedal path.
- On each audio sample strobe it:
  - captures the delayed tap from the buffer;
  - computes the wet output mix and the feedback write value, both with saturation;
  - issues exactly one write (en+we) to the buffer.
- Sits between the ADC-side sample stream and the DAC-side output, and owns all delay-buffer control.

Parameters:
- DATA_WIDTH, 24: signed sample width, shared with the buffer.
- GAIN_WIDTH, 8: unsigned gain width; gain value g means g/2^GAIN_WIDTH.
- FIFO_DEPTH, 4800: buffer depth, equal to the delay length in samples. Must match the buffer instance.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle sample strobe
- in_data  in  DATA_WIDTH  signed input sample; valid with in_valid
- in_ready  out  1  high in IDLE
- out_valid  out  1  one-cycle pulse, processed sample ready
- out_data  out  DATA_WIDTH  signed processed sample
- fb_gain  in  GAIN_WIDTH  feedback gain
- mix_gain  in  GAIN_WIDTH  wet level
- bypass  in  1  out_data = dry input
- freeze  in  1  loop buffer contents, ignore new input for the write
- flush  in  1  one-cycle pulse, restart priming
- overrun  out  1  sticky dropped-strobe flag
- ovr_clr  in  1  clears overrun
- buf_en  out  1  to buffer en
- buf_we  out  1  to buffer we
- buf_wr_data  out  DATA_WIDTH  to buffer data_i
- buf_rd_data  in  DATA_WIDTH  from buffer data_o: registered mem[wr_ptr], the oldest sample

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous and active-low.
  - Asserting rst_n low immediately forces state IDLE and sets every output to 0 (except in_ready=1).
  - Fill count = 0.
  - A reset mid-sequence aborts the sequence with no buffer write.
- FSM: IDLE -> CAPT -> CALC -> WRITE -> IDLE, one cycle per state.
  - IDLE: when in_valid is high, latch in_data and go to CAPT.
  - CAPT: latch tap = primed ? buf_rd_data : 0. Latch fb_gain, mix_gain, bypass and freeze.
  - CALC: compute the wet product, the write value and the output value. Register the results.
  - WRITE: drive buf_en=buf_we=1 and buf_wr_data for exactly one cycle. Pulse out_valid=1 with out_data valid. Increment the fill count.
- Latency: out_valid arrives 3 cycles after the in_valid cycle.
  - Minimum strobe spacing is 4 cycles; a strobe exactly 4 cycles later is accepted.
  - This guarantees buf_rd_data has settled after the pointer advance.
- Overrun: in_valid while not in IDLE is dropped.
  - No out_valid or write results from it.
  - overrun is set the next cycle and held until ovr_clr.
  - If set and clear coincide, set wins.
- Arithmetic:
  - product = signed tap × unsigned gain, full width DATA_WIDTH+GAIN_WIDTH+1, then arithmetic shift right by GAIN_WIDTH (floor).
  - Sums are formed at DATA_WIDTH+1 bits and saturated to [-2^(DW-1), 2^(DW-1)-1].
- Normal operation:
  - buf_wr_data = sat(in + (tap·fb)>>G)
  - out_data = sat(in + (tap·mix)>>G)
- Modifiers:
  - freeze (when primed): buf_wr_data = tap, unscaled. freeze before primed has no effect.
  - bypass: out_data = in. Buffer writes continue unchanged, so trails keep building.
  - freeze and bypass together: out = in, write = tap.
- Priming:
  - The buffer memory has no reset. The fill counter counts writes and saturates at FIFO_DEPTH.
  - primed = (count == FIFO_DEPTH). While not primed, the tap reads as 0.
  - flush zeroes the count at the next edge, in any state.
  - A write in progress still completes.
  - If flush coincides with WRITE, the count ends at 0.
- Outputs hold their values between pulses. out_data is held after out_valid drops.

Test Plan:
- Reset (FIFO_DEPTH=4): hold rst_n=0, then release -> in_ready=1; out_valid, buf_en, buf_we, overrun, out_data all 0. Assert rst_n low during CALC -> no buf_en pulse.
- Impulse (DEPTH=4, fb=0, mix=128): samples 1000,0,0,0,0 at 8-cycle spacing -> out_data 1000,0,0,0,500. Each out_valid comes 3 cycles after its strobe. buf_en is high for one cycle per sample.
- Feedback decay (fb=128, mix=255): impulse 1024, then zeros -> sample 5 gives out 1020 and write 512; sample 9 gives out 510 and write 256.
- Saturation (mix=255): in=8388600 with tap=8000000 -> out 8388607. in=-8388600 with tap=-8000000 -> out -8388608.
- Overrun: strobes at cycles 0 and 2 -> one out_valid, one write, overrun=1. Pulse ovr_clr -> overrun=0. A strobe at cycle 4 is accepted.
- Freeze/flush: primed with 10,20,30,40, set freeze=1 with new inputs of 99 -> writes repeat 10,20,30,40. Pulse flush -> the next 4 taps are 0 (out equals in).

Source files
------------

// File: rtl/echo_ctrl.sv
// -----------------------------------------------------------------------------
// echo_ctrl
//   Sample-rate sequencer for the single-port circular delay buffer in the
//   echo/delay pedal path. For every accepted input sample it reads the
//   delayed tap, forms the wet output mix and the feedback write value (both
//   saturated), and issues exactly one write strobe to the buffer.
//
//   Sequence per sample: IDLE -> CAPT -> CALC -> WRITE -> IDLE.
//   out_valid rises 3 cycles after the accepted in_valid cycle.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   in_valid     one-cycle sample strobe (accepted only in IDLE)
//   in_data      signed input sample, valid with in_valid
//   in_ready     high while IDLE
//   out_valid    one-cycle pulse, out_data carries the processed sample
//   out_data     signed processed sample, held between pulses
//   fb_gain      feedback gain, g / 2^GAIN_WIDTH
//   mix_gain     wet level, g / 2^GAIN_WIDTH
//   bypass       out_data = dry input (buffer writes continue)
//   freeze       once primed, write the tap back unchanged
//   flush        one-cycle pulse, restart priming
//   overrun      sticky flag: a strobe arrived while busy and was dropped
//   ovr_clr      clears overrun (a coincident set wins)
//   buf_en       buffer enable
//   buf_we       buffer write enable
//   buf_wr_data  buffer write data
//   buf_rd_data  buffer read data: registered mem[wr_ptr], the oldest sample
// -----------------------------------------------------------------------------
module echo_ctrl #(
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_WIDTH = 8,
    parameter int FIFO_DEPTH = 4800
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    input  logic        [GAIN_WIDTH-1:0] fb_gain,
    input  logic        [GAIN_WIDTH-1:0] mix_gain,
    input  logic                         bypass,
    input  logic                         freeze,
    input  logic                         flush,
    output logic                         overrun,
    input  logic                         ovr_clr,
    output logic                         buf_en,
    output logic                         buf_we,
    output logic signed [DATA_WIDTH-1:0] buf_wr_data,
    input  logic signed [DATA_WIDTH-1:0] buf_rd_data
);

    // Sums carry one guard bit; the product is tap x {0,gain}.
    localparam int SW = DATA_WIDTH + 1;
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAPT  = 2'd1,
        S_CALC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Datapath registers
    logic signed [DATA_WIDTH-1:0] r_in;
    logic signed [DATA_WIDTH-1:0] r_tap;
    logic        [GAIN_WIDTH-1:0] r_fb;
    logic        [GAIN_WIDTH-1:0] r_mix;
    logic                         r_byp;
    logic                         r_frz_live;
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic signed [DATA_WIDTH-1:0] r_wr_data;

    // Control registers
    logic [CW-1:0] r_fill_cnt;
    logic          r_overrun;

    // Combinational datapath
    logic                         w_primed;
    logic signed [DATA_WIDTH-1:0] w_tap;
    logic signed [SW-1:0]         w_in_ext;
    logic signed [SW-1:0]         w_sum_mix;
    logic signed [SW-1:0]         w_sum_fb;
    logic signed [DATA_WIDTH-1:0] w_out_val;
    logic signed [DATA_WIDTH-1:0] w_wr_val;
    logic                         w_drop;

    // Signed tap times unsigned gain, then floor division by 2^GAIN_WIDTH.
    // The shifted result always fits in DATA_WIDTH+1 bits because gain < 1.
    function automatic logic signed [SW-1:0] f_scale(
        input logic signed [DATA_WIDTH-1:0] tap,
        input logic        [GAIN_WIDTH-1:0] gain
    );
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        logic signed [PW-1:0] prod;
        a    = PW'(tap);
        b    = PW'($signed({1'b0, gain}));
        prod = a * b;
        return prod[PW-1:GAIN_WIDTH];
    endfunction

    // Clamp a guard-bit sum back to the sample range.
    function automatic logic signed [DATA_WIDTH-1:0] f_sat(
        input logic signed [SW-1:0] s
    );
        if (s[SW-1] != s[SW-2]) begin
            return s[SW-1] ? SAT_MIN : SAT_MAX;
        end
        return s[DATA_WIDTH-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid) w_next_state = S_CAPT;
            S_CAPT:  w_next_state = S_CALC;
            S_CALC:  w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        buf_en    = 1'b0;
        buf_we    = 1'b0;
        unique case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_WRITE: begin
                out_valid = 1'b1;
                buf_en    = 1'b1;
                buf_we    = 1'b1;
            end
            default: ;
        endcase
    end

    // Buffer contents are unreset; until FIFO_DEPTH writes have landed the
    // read port may hold garbage, so the tap is forced to zero.
    assign w_primed = (r_fill_cnt == CNT_FULL);
    assign w_tap    = w_primed ? buf_rd_data : '0;

    assign w_in_ext  = $signed({r_in[DATA_WIDTH-1], r_in});
    assign w_sum_mix = w_in_ext + f_scale(r_tap, r_mix);
    assign w_sum_fb  = w_in_ext + f_scale(r_tap, r_fb);

    assign w_out_val = r_byp      ? r_in  : f_sat(w_sum_mix);
    assign w_wr_val  = r_frz_live ? r_tap : f_sat(w_sum_fb);

    assign w_drop = in_valid && (r_state != S_IDLE);

    // -------------------------------------------------------------------------
    // Datapath: input latch (IDLE), tap/controls (CAPT), results (CALC)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in       <= '0;
            r_tap      <= '0;
            r_fb       <= '0;
            r_mix      <= '0;
            r_byp      <= 1'b0;
            r_frz_live <= 1'b0;
            r_out_data <= '0;
            r_wr_data  <= '0;
        end else begin
            if ((r_state == S_IDLE) && in_valid) begin
                r_in <= in_data;
            end
            if (r_state == S_CAPT) begin
                r_tap      <= w_tap;
                r_fb       <= fb_gain;
                r_mix      <= mix_gain;
                r_byp      <= bypass;
                // freeze has no effect until the buffer holds real samples
                r_frz_live <= freeze && w_primed;
            end
            if (r_state == S_CALC) begin
                r_out_data <= w_out_val;
                r_wr_data  <= w_wr_val;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Fill counter: counts completed writes, saturates at FIFO_DEPTH.
    // flush has priority so a flush during WRITE leaves the count at zero.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt <= '0;
        end else if (flush) begin
            r_fill_cnt <= '0;
        end else if ((r_state == S_WRITE) && !w_primed) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overrun: set beats clear when both happen in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign out_data    = r_out_data;
    assign buf_wr_data = r_wr_data;
    assign overrun     = r_overrun;

endmodule
